// File: rtl/pc_fetch_unit.sv
// Purpose : architectural PC register and single-outstanding instruction fetch sequencer.
// Latency : 3 cycles minimum per instruction (request accepted, data returned, ack in first hold cycle).
// Backpressure: request held stable until i_imem_ready; i_stall gates new fetches only from idle/ack.
//
// Ports:
//   i_clk, i_rst          clock (rising edge), asynchronous active-high reset
//   i_stall               hold off starting a new fetch
//   i_nextpc, i_pcsrc     branch/jump target and select, sampled with i_instr_ack
//   i_instr_ack           consumer executed o_instr this cycle
//   o_instr, o_instr_valid buffered instruction and its valid flag
//   o_pc, o_pc_plus4      PC of the buffered/current instruction and PC+4
//   o_imem_req/addr       fetch request; address is always o_pc
//   i_imem_ready          memory accepts the request this cycle
//   i_imem_rvalid/rdata   read response
//   o_retired             count of acknowledged instructions (wraps)
//   o_misalign            sticky flag: a taken target had nonzero low bits
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_stall,
    input  logic [31:0]      i_nextpc,
    input  logic             i_pcsrc,
    input  logic             i_instr_ack,
    output logic [31:0]      o_instr,
    output logic             o_instr_valid,
    output logic [31:0]      o_pc,
    output logic [31:0]      o_pc_plus4,
    output logic             o_imem_req,
    output logic [31:0]      o_imem_addr,
    input  logic             i_imem_ready,
    input  logic             i_imem_rvalid,
    input  logic [31:0]      i_imem_rdata,
    output logic [CNT_W-1:0] o_retired,
    output logic             o_misalign
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        capture;
    logic        ack_take;
    logic [31:0] pc_next;

    assign o_pc_plus4  = o_pc + 32'd4;
    assign o_imem_addr = o_pc;

    // Low two bits of a taken target are dropped; the misalign flag records that it happened.
    assign pc_next = i_pcsrc ? {i_nextpc[31:2], 2'b00} : o_pc_plus4;

    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        ack_take = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!i_stall) state_d = S_REQ;
            end
            S_REQ: begin
                // Once raised, the request is never withdrawn, so stall is not looked at here.
                if (i_imem_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (i_imem_rvalid) begin
                    capture = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (i_instr_ack && o_instr_valid) begin
                    ack_take = 1'b1;
                    state_d  = i_stall ? S_IDLE : S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= S_IDLE;
            o_pc          <= RESET_PC;
            o_imem_req    <= 1'b0;
            o_instr       <= 32'h0000_0000;
            o_instr_valid <= 1'b0;
            o_retired     <= '0;
            o_misalign    <= 1'b0;
        end else begin
            state_q    <= state_d;
            // Registered request: high exactly while the FSM sits in S_REQ.
            o_imem_req <= (state_d == S_REQ);
            if (capture) begin
                o_instr       <= i_imem_rdata;
                o_instr_valid <= 1'b1;
            end
            if (ack_take) begin
                o_instr_valid <= 1'b0;
                o_pc          <= pc_next;
                o_retired     <= o_retired + CNT_W'(1);
                if (i_pcsrc && (i_nextpc[1:0] != 2'b00)) o_misalign <= 1'b1;
            end
        end
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch sequencer for the unpipelined MIPS core.
- Holds the architectural PC and issues word fetches to instruction memory over a req/ready + rvalid handshake.
- Buffers the returned instruction for the decode/execute logic.
- On instruction consumption, loads either PC+4 or the branch/jump target produced by nextPC (i_nextpc/i_pcsrc).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned).
CNT_W, 16, width of the retired-instruction counter.

Ports:
i_clk  input  1  system clock, rising edge.
i_rst  input  1  asynchronous, active-high reset.
i_stall  input  1  hold off new fetches.
i_nextpc  input  32  branch/jump target from nextPC.
i_pcsrc  input  1  1 = take i_nextpc, 0 = sequential PC+4.
i_instr_ack  input  1  consumer has executed o_instr this cycle.
o_instr  output  32  buffered instruction.
o_instr_valid  output  1  o_instr holds a fetched, unconsumed instruction.
o_pc  output  32  PC of the current/buffered instruction.
o_pc_plus4  output  32  o_pc + 4, combinational.
o_imem_req  output  1  fetch request.
o_imem_addr  output  32  fetch address; equals o_pc.
i_imem_ready  input  1  memory accepts request this cycle.
i_imem_rvalid  input  1  read data valid.
i_imem_rdata  input  32  read data.
o_retired  output  CNT_W  count of acknowledged instructions.
o_misalign  output  1  sticky: a taken target had nonzero bits [1:0].

Behaviour:
- Reset (asynchronous, immediate):
  - State = S_IDLE.
  - o_pc = RESET_PC; o_imem_req = 0; o_instr = 0; o_instr_valid = 0; o_retired = 0; o_misalign = 0.
- FSM states: S_IDLE, S_REQ, S_WAIT, S_HOLD. All outputs are registered except o_pc_plus4 and o_imem_addr.
- S_IDLE:
  - o_imem_req = 0.
  - If i_stall = 0, go to S_REQ next cycle; otherwise remain.
- S_REQ:
  - o_imem_req = 1 and o_imem_addr = o_pc, held stable until accepted.
  - i_imem_ready = 1 ends the handshake; go to S_WAIT.
  - i_stall is ignored once in S_REQ; a request is never withdrawn.
- S_WAIT:
  - o_imem_req = 0.
  - On i_imem_rvalid = 1, capture i_imem_rdata into o_instr, set o_instr_valid = 1 next cycle, and go to S_HOLD.
  - Wait indefinitely otherwise.
- i_imem_rvalid outside S_WAIT is ignored; memory never returns data in the acceptance cycle.
- S_HOLD:
  - o_instr and o_pc are held stable.
  - On i_instr_ack = 1 (the same cycle in which i_pcsrc/i_nextpc are valid for that instruction):
    - o_pc <= i_pcsrc ? {i_nextpc[31:2], 2'b00} : o_pc + 4.
    - o_instr_valid <= 0.
    - o_retired <= o_retired + 1.
    - Next state is S_REQ if i_stall = 0, else S_IDLE.
- i_instr_ack is ignored when o_instr_valid = 0.
- Misalignment: if i_pcsrc = 1 on an ack and i_nextpc[1:0] != 0:
  - o_misalign is set and stays set until reset.
  - The PC still loads the target with bits [1:0] cleared.
- Arithmetic:
  - PC+4 is modulo 2^32, so 32'hFFFF_FFFC -> 32'h0000_0000.
  - o_retired wraps modulo 2^CNT_W.
- Throughput: minimum 3 cycles per instruction (REQ accepted at once, rvalid the next cycle, ack in the first HOLD cycle).
- Reset mid-transaction:
  - The FSM aborts to S_IDLE.
  - The instruction memory shares i_rst; any in-flight response is discarded because the FSM is not in S_WAIT.

Test Plan:
- Reset release with RESET_PC = 0, i_stall = 0, ready = 1, rvalid one cycle later with rdata = 32'h2008_0005:
  - S_REQ one cycle after reset deassertion with o_imem_addr = 0.
  - o_instr = 32'h2008_0005 and valid on the third cycle.
- Sequential run, three acks with i_pcsrc = 0:
  - o_pc steps 0 -> 4 -> 8 -> C.
  - o_retired = 3.
- Taken branch: ack with i_pcsrc = 1, i_nextpc = 32'h0000_0040:
  - Next request address = 32'h40.
  - o_misalign stays 0.
- Misaligned target i_nextpc = 32'h0000_0043 with i_pcsrc = 1:
  - Next address = 32'h40.
  - o_misalign = 1 and stays 1 through later good fetches.
- Backpressure: i_imem_ready low for 4 cycles, then i_stall high at ack:
  - o_imem_req and o_imem_addr are held stable for 4 cycles.
  - After the stalled ack the FSM sits in S_IDLE with o_imem_req = 0 until i_stall drops.
- Wrap and async reset: o_pc = 32'hFFFF_FFFC, ack with i_pcsrc = 0:
  - Next address = 0.
  - Asserting i_rst mid-S_WAIT immediately clears o_instr_valid and o_imem_req, and returns o_pc to RESET_PC.
